opamp_trim_ctrl: RTL

OPAMP_TRIM_CTRL -- requirements
Module: opamp_trim_ctrl

---
 rtl/opamp_ctrl_pkg.sv | 16 +
 rtl/cmp_sync.sv | 24 ++
 rtl/opamp_trim_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/opamp_ctrl_pkg.sv
// Shared types and default sizing for the opamp offset-trim controller.
package opamp_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PWRUP,
        SETTLE,
        DECIDE,
        DONE
    } state_e;

    localparam int DEF_TRIM_W     = 6;
    localparam int DEF_PWRUP_CYC  = 64;
    localparam int DEF_SETTLE_CYC = 16;

endpackage

// File: rtl/cmp_sync.sv
// Two-flop synchronizer that brings the asynchronous comparator output into the clk domain.
module cmp_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/opamp_trim_ctrl.sv
// SAR offset calibration controller: warms up the opamp, then binary-searches the trim DAC
// code using the comparator-mode output, restoring the previous trim if aborted.
module opamp_trim_ctrl
    import opamp_ctrl_pkg::*;
#(
    parameter int TRIM_W     = DEF_TRIM_W,
    parameter int PWRUP_CYC  = DEF_PWRUP_CYC,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    input  logic              cmp_in,
    input  logic              trim_wr,
    input  logic [TRIM_W-1:0] trim_din,
    output logic              amp_en,
    output logic              sw_cal,
    output logic [TRIM_W-1:0] trim,
    output logic              busy,
    output logic              done,
    output logic              sat
);

    localparam int CNT_MAX = (PWRUP_CYC > SETTLE_CYC) ? PWRUP_CYC : SETTLE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TRIM_W-1:0] trim_q, trim_d;
    logic [TRIM_W-1:0] saved_q, saved_d;
    logic              done_q, done_d;
    logic              sat_q, sat_d;
    logic              cmp_s;
    logic              in_cal;
    logic              finishing;

    cmp_sync u_cmp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (cmp_in),
        .q_o   (cmp_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            trim_q  <= '0;
            saved_q <= '0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            trim_q  <= trim_d;
            saved_q <= saved_d;
            done_q  <= done_d;
            sat_q   <= sat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        trim_d  = trim_q;
        saved_d = saved_q;
        done_d  = done_q;
        sat_d   = sat_q;

        if ((state_q == IDLE || state_q == DONE) && ena && start) begin
            state_d = PWRUP;
            cnt_d   = '0;
            saved_d = trim_q;
            trim_d  = '0;
            trim_d[TRIM_W-1] = 1'b1;
            done_d  = 1'b0;
            sat_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (trim_wr) begin
                        trim_d = trim_din;
                        sat_d  = 1'b0;
                    end
                end
                PWRUP, SETTLE, DECIDE: begin
                    if (!ena) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        trim_d  = saved_q;
                        done_d  = 1'b0;
                        sat_d   = 1'b0;
                    end else if (state_q == PWRUP) begin
                        if (cnt_q == CNT_W'(PWRUP_CYC - 1)) begin
                            state_d = SETTLE;
                            cnt_d   = '0;
                            idx_d   = IDX_W'(TRIM_W - 1);
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (state_q == SETTLE) begin
                        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                            state_d = DECIDE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        // cmp high means the trim is too large, so this trial bit is dropped.
                        if (cmp_s) begin
                            trim_d[idx_q] = 1'b0;
                        end
                        if (idx_q != '0) begin
                            trim_d[idx_q - IDX_W'(1)] = 1'b1;
                            idx_d   = idx_q - IDX_W'(1);
                            state_d = SETTLE;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (!ena) begin
                        state_d = IDLE;
                        done_d  = 1'b0;
                    end else begin
                        // First DONE cycle registers the result flags from the final code.
                        if (!done_q) begin
                            done_d = 1'b1;
                            sat_d  = (trim_q == '0) || (trim_q == '1);
                        end
                        if (trim_wr) begin
                            trim_d = trim_din;
                            sat_d  = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign in_cal    = (state_q == PWRUP) || (state_q == SETTLE) || (state_q == DECIDE);
    assign finishing = (state_q == DONE) && !done_q;

    assign amp_en = (state_q != IDLE);
    assign sw_cal = in_cal || finishing;
    assign busy   = in_cal || finishing;
    assign done   = done_q;
    assign sat    = sat_q;
    assign trim   = trim_q;

endmodule
